cell_uart_tx: RTL and testbench
===============================

# cell_uart_tx

Transmit-side bridge between the cell array and the UART transmitter. It accepts packed cell messages `{i, j, status}` through a valid/ack handshake and queues them in a small FIFO. Each message is serialized as three bytes (i, j, status) over the UART TX `send`/`txdone` interface. It is the outbound counterpart of the UART-to-cell receive path in `Buffer` and uses the same message format.

## Interface
- `ADDR_WIDTH`, default 4: cell coordinate width; i and j fields are `ADDR_WIDTH+1` bits.
- `DEPTH`, default 4: FIFO depth in messages; must be a power of two, at least 2.
- `MESSAGE_WIDTH` (localparam): `2*(ADDR_WIDTH+1)+4`, which is 14 at the default.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `txmessage`  in  MESSAGE_WIDTH: message `{i[ADDR_WIDTH:0], j[ADDR_WIDTH:0], status[3:0]}`.
- `txmessage_valid`  in  1: producer offers `txmessage`.
- `ack_txmessage`  out  1: one-cycle pulse; the message was written to the FIFO.
- `txdata`  out  8: byte to the UART TX.
- `send`  out  1: level; `txdata` is valid and held stable while high.
- `txdone`  in  1: one-cycle pulse from the UART TX when the current byte has finished.
- `count`  out  $clog2(DEPTH)+1: FIFO occupancy.
- `busy`  out  1: high while serializing a message or while `count != 0`.

## Operation
- **Accept**
  - Condition: at an edge where `txmessage_valid=1`, `count<DEPTH` and `ack_txmessage=0`.
  - Action: write `txmessage` at the write pointer and set `ack_txmessage=1` for the next cycle only.
  - While `ack_txmessage=1`, no write occurs. This prevents a held `txmessage_valid` from double-writing, so the maximum accept rate is one message per 2 cycles.
  - The producer drops or changes `txmessage` after it sees the ack.
- **Full:** no write and no ack; `txmessage_valid` keeps waiting.
- **Byte mapping:** each byte field is zero-extended to 8 bits.
  - byte0 = `{0, i}`
  - byte1 = `{0, j}`
  - byte2 = `{4'b0, status}`
- **FSM:** states IDLE, SEND, GAP; 2-bit byte index `bidx`.
  - **IDLE:**
    - If `count!=0`: pop the FIFO head into a holding register, set `bidx=0`, `txdata=byte0`, `send=1`, and go to SEND.
    - Otherwise stay in IDLE.
  - **SEND:** hold `send=1` and `txdata` until `txdone=1`.
    - If `txdone=1` and `bidx<2`: `send=0`, `bidx++`, go to GAP.
    - If `txdone=1` and `bidx==2`: `send=0`, go to IDLE.
  - **GAP:** exactly one cycle, then `send=1`, `txdata` = byte[`bidx`], go to SEND.
- `txdone` is ignored in IDLE and GAP.
- A pop and a write in the same edge are both performed; `count` is unchanged by the pair.
- Pointers are `$clog2(DEPTH)` bits wide and wrap modulo DEPTH. `count` alone distinguishes full from empty.
- Message order on the UART equals accept order.

## Timing
- **Reset values:** `send=0`, `txdata=8'h00`, `ack_txmessage=0`, `count=0`, `busy=0`, state IDLE, pointers 0.
- **Reset mid-operation:** outputs and state return to the reset values immediately (asynchronous). The FIFO contents and any partial message are discarded; the UART may see a truncated message.
- **Accept latency:** `ack_txmessage` is high in the cycle after the accepting edge.
- **Launch latency:** from accept edge t, with IDLE and the FIFO empty, `send` rises at edge t+1.
- **Inter-byte:** `txdone` at edge e gives `send=0` after e and `send=1` with the next byte after e+1 (one-cycle gap).
- **Inter-message:** the last `txdone` at edge e gives IDLE after e. If the FIFO is non-empty, `send` rises after e+1. The minimum gap between messages is one cycle, the same as between bytes.
- **busy:** asserted after the accepting edge; deasserted after the final-byte `txdone` when the FIFO is empty.

## Test plan
- **Reset:** apply `rst` mid-SEND -> `send=0`, `count=0`, and no further bytes after release even if the FIFO held messages.
- **Single message:** i=3, j=10, status=9, with `txdone` returned 5 cycles after each `send` rise -> bytes `0x03`, `0x0A`, `0x09`. Check `send` low for exactly 1 cycle between bytes, `ack_txmessage` as a single pulse, and `busy` falling after the third `txdone`.
- **Full FIFO:** hold `txdone` low and offer 6 messages.
  - `ack_txmessage` pulses for 5 messages: 1 in the holding register plus 4 in the FIFO, so `count=4`.
  - The 6th message is stalled with no ack until the first message completes and a pop occurs.
  - All 6 are then sent in order.
- **Held valid:** keep `txmessage_valid` high with the same message for 10 cycles -> it is written each time `ack_txmessage` is low. The bench checks for exactly one write per ack pulse, and `count` increments by 1 per pulse.
- **Simultaneous:** accept a message on the same edge as an IDLE pop with `count=2` -> `count` stays 2 and the order is preserved.
- **Wrap-around:** stream 3*DEPTH+1 random messages with random `txdone` delays of 1..8 cycles -> a scoreboard matches every byte triple, with no loss and no duplication. A stray `txdone` pulse in IDLE and in GAP is ignored.

Source files
------------

// File: rtl/cell_uart_tx_if.sv
// Handshake bundle for cell_uart_tx.
// The producer side offers packed cell messages and receives an ack.
// The UART side receives bytes with send and returns a txdone pulse.
// master = environment (producer + UART TX), slave = the bridge.
interface cell_uart_tx_if #(
  parameter int ADDR_WIDTH = 4
);
  localparam int MESSAGE_WIDTH = 2 * (ADDR_WIDTH + 1) + 4;

  logic [MESSAGE_WIDTH-1:0] txmessage;
  logic                     txmessage_valid;
  logic                     ack_txmessage;
  logic [7:0]               txdata;
  logic                     send;
  logic                     txdone;

  modport master (
    output txmessage, txmessage_valid, txdone,
    input  ack_txmessage, txdata, send
  );

  modport slave (
    input  txmessage, txmessage_valid, txdone,
    output ack_txmessage, txdata, send
  );
endinterface

// File: rtl/cell_uart_tx.sv
// Transmit bridge from the cell array to a byte-wide UART TX.
// Packed {i, j, status} messages are queued in a small FIFO and each
// message is sent as three zero-extended bytes: i, j, status.
module cell_uart_tx #(
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  cell_uart_tx_if.slave          bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy
);

  localparam int AW1 = ADDR_WIDTH + 1;
  localparam int MW  = 2 * AW1 + 4;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] hold;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          wr_en;
  logic          pop_en;
  logic          ack_r;
  logic          send_r;
  logic [7:0]    txdata_r;
  logic [1:0]    bidx;
  state_t        state;

  // Pick byte idx of a message, each field zero-extended to 8 bits.
  function automatic logic [7:0] msg_byte(input logic [MW-1:0] m, input logic [1:0] idx);
    logic [7:0] b;
    b = '0;
    case (idx)
      2'd0:    b[AW1-1:0] = m[MW-1 -: AW1];
      2'd1:    b[AW1-1:0] = m[4 +: AW1];
      default: b[3:0]     = m[3:0];
    endcase
    return b;
  endfunction

  // The ack cycle blocks a second write so a held valid cannot double-write.
  assign wr_en  = bus.txmessage_valid && (count < FULL_CNT) && !ack_r;
  assign pop_en = (state == IDLE) && (count != '0);
  assign busy   = (state != IDLE) || (count != '0);

  assign bus.ack_txmessage = ack_r;
  assign bus.send          = send_r;
  assign bus.txdata        = txdata_r;

  // FIFO storage and the holding register for the message being serialized.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wptr] <= bus.txmessage;
    if (pop_en)
      hold <= mem[rptr];
  end

  // FIFO pointers, occupancy and the one-cycle accept pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ack_r <= 1'b0;
    end else begin
      ack_r <= wr_en;
      if (wr_en)
        wptr <= wptr + PW'(1);
      if (pop_en)
        rptr <= rptr + PW'(1);
      case ({wr_en, pop_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Serializer: launch byte0 on pop, wait for txdone, one idle cycle between bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bidx     <= 2'd0;
      send_r   <= 1'b0;
      txdata_r <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (pop_en) begin
            bidx     <= 2'd0;
            txdata_r <= msg_byte(mem[rptr], 2'd0);
            send_r   <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (bus.txdone) begin
            send_r <= 1'b0;
            if (bidx == 2'd2) begin
              state <= IDLE;
            end else begin
              bidx  <= bidx + 2'd1;
              state <= GAP;
            end
          end
        end
        GAP: begin
          txdata_r <= msg_byte(hold, bidx);
          send_r   <= 1'b1;
          state    <= SEND;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_uart_tx.sv
// Bench for cell_uart_tx: table vectors, hand sequences for multi-cycle
// corner cases and a byte scoreboard fed at accept time.
module tb_cell_uart_tx;
  localparam int AW    = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] count;
  logic       busy;

  cell_uart_tx_if #(.ADDR_WIDTH(AW)) bus();

  cell_uart_tx #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .count (count),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] i;
    logic [4:0] j;
    logic [3:0] st;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
  } vec_t;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  bit         uart_en   = 1'b0;
  bit         uart_rand = 1'b0;
  int         uart_dly  = 5;
  bit         stray_req = 1'b0;
  int         done_cnt  = 0;
  int         n_rises   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [13:0] m, input int k);
    case (k)
      0:       return {3'b000, m[13:9]};
      1:       return {3'b000, m[8:4]};
      default: return {4'h0, m[3:0]};
    endcase
  endfunction

  task automatic push_msg(input logic [13:0] m);
    for (int k = 0; k < 3; k++)
      exp_q.push_back(exp_byte(m, k));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offer a message; on ack, its bytes join the scoreboard and valid drops.
  task automatic offer(input logic [13:0] m, input int maxc, output bit ok);
    bus.txmessage       = m;
    bus.txmessage_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (bus.ack_txmessage === 1'b1) begin
        ok = 1'b1;
        push_msg(m);
        break;
      end
    end
    if (ok)
      bus.txmessage_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int maxc);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (busy === 1'b0 && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 32'(ok), 32'd1);
    chk({name, "_count"}, 32'(count), 32'd0);
  endtask

  // UART TX model: samples 2 time units after each rising edge, checks every
  // launched byte against the scoreboard and returns txdone after a delay.
  initial begin : uart_model
    logic       prev_send;
    logic [7:0] cur_byte;
    int         wait_cnt;
    int         low_cnt;
    int         bim;
    bit         in_byte;
    prev_send = 1'b0;
    cur_byte  = 8'h00;
    wait_cnt  = 0;
    low_cnt   = 0;
    bim       = 0;
    in_byte   = 1'b0;
    bus.txdone = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.txdone = 1'b0;
      if (rst) begin
        prev_send = 1'b0;
        in_byte   = 1'b0;
        low_cnt   = 0;
        bim       = 0;
      end else begin
        if (bus.send && !prev_send) begin
          n_rises++;
          if (bim != 0)
            chk("inter_byte_gap", 32'(low_cnt), 32'd1);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_byte: got 0x%0h, expected no byte", bus.txdata);
          end else begin
            chk("byte", 32'(bus.txdata), 32'(exp_q.pop_front()));
          end
          cur_byte = bus.txdata;
          in_byte  = 1'b1;
          wait_cnt = uart_rand ? int'($urandom_range(8, 1)) : uart_dly;
          low_cnt  = 0;
        end else if (bus.send) begin
          chk("txdata_stable", 32'(bus.txdata), 32'(cur_byte));
        end else begin
          low_cnt++;
        end
        if (in_byte && uart_en) begin
          if (wait_cnt <= 1) begin
            bus.txdone = 1'b1;
            in_byte    = 1'b0;
            done_cnt++;
            bim = (bim == 2) ? 0 : bim + 1;
          end else begin
            wait_cnt--;
          end
        end else if (!bus.send && stray_req) begin
          bus.txdone = 1'b1;
          stray_req  = 1'b0;
        end
        prev_send = bus.send;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t       vecs[4];
    int         hv_cnt[5];
    bit         ok;
    bit         got;
    int         acks;
    int         d0;
    int         target;
    int         r0;
    logic       prev_ack;
    logic [13:0] m;

    vecs[0] = '{i: 5'd3,  j: 5'd10, st: 4'd9,  b0: 8'h03, b1: 8'h0A, b2: 8'h09};
    vecs[1] = '{i: 5'd31, j: 5'd31, st: 4'd15, b0: 8'h1F, b1: 8'h1F, b2: 8'h0F};
    vecs[2] = '{i: 5'd0,  j: 5'd0,  st: 4'd0,  b0: 8'h00, b1: 8'h00, b2: 8'h00};
    vecs[3] = '{i: 5'd16, j: 5'd1,  st: 4'd8,  b0: 8'h10, b1: 8'h01, b2: 8'h08};
    hv_cnt  = '{1, 1, 2, 3, 4};

    rst = 1'b1;
    bus.txmessage       = '0;
    bus.txmessage_valid = 1'b0;
    cycles(2);
    chk("rst_send",   32'(bus.send), 32'd0);
    chk("rst_txdata", 32'(bus.txdata), 32'h00);
    chk("rst_ack",    32'(bus.ack_txmessage), 32'd0);
    chk("rst_count",  32'(count), 32'd0);
    chk("rst_busy",   32'(busy), 32'd0);
    rst = 1'b0;
    cycles(2);
    chk("idle_send", 32'(bus.send), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Table vectors: single messages with txdone 5 cycles after each send rise.
    uart_en = 1'b1; uart_rand = 1'b0; uart_dly = 5;
    for (int v = 0; v < 4; v++) begin
      d0 = done_cnt;
      bus.txmessage       = {vecs[v].i, vecs[v].j, vecs[v].st};
      bus.txmessage_valid = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (bus.ack_txmessage === 1'b1) begin
          got = 1'b1;
          break;
        end
      end
      chk("vec_ack_seen", 32'(got), 32'd1);
      exp_q.push_back(vecs[v].b0);
      exp_q.push_back(vecs[v].b1);
      exp_q.push_back(vecs[v].b2);
      bus.txmessage_valid = 1'b0;
      chk("vec_launch_send_low", 32'(bus.send), 32'd0);
      chk("vec_busy_after_accept", 32'(busy), 32'd1);
      @(negedge clk);
      chk("vec_ack_single_pulse", 32'(bus.ack_txmessage), 32'd0);
      chk("vec_launch_send_high", 32'(bus.send), 32'd1);
      got = 1'b0;
      for (int k = 0; k < 100; k++) begin
        if (done_cnt == d0 + 3) begin
          got = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk("vec_three_txdone", 32'(got), 32'd1);
      chk("vec_busy_before_last_done", 32'(busy), 32'd1);
      @(negedge clk);
      chk("vec_busy_after_last_done", 32'(busy), 32'd0);
      chk("vec_bytes_consumed", 32'(exp_q.size()), 32'd0);
    end

    // Held valid with the UART stalled: one write per ack pulse.
    uart_en = 1'b0;
    m = {5'd7, 5'd20, 4'd5};
    bus.txmessage       = m;
    bus.txmessage_valid = 1'b1;
    acks = 0;
    prev_ack = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.ack_txmessage === 1'b1) begin
        chk("held_no_back_to_back", 32'(prev_ack), 32'd0);
        if (acks < 5)
          chk("held_count", 32'(count), 32'(hv_cnt[acks]));
        acks++;
        push_msg(m);
      end
      prev_ack = bus.ack_txmessage;
    end
    bus.txmessage_valid = 1'b0;
    chk("held_acks", 32'(acks), 32'd5);
    @(negedge clk);
    chk("held_count_full", 32'(count), 32'd4);
    uart_en = 1'b1; uart_dly = 1;
    wait_idle("held_drain", 300);

    // Full FIFO: five accepted, the sixth stalls until a pop frees space.
    uart_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      offer({5'(k + 1), 5'(2 * k + 3), 4'(k + 10)}, 10, ok);
      chk("full_accept", 32'(ok), 32'd1);
    end
    chk("full_count", 32'(count), 32'd4);
    m = {5'd30, 5'd17, 4'd2};
    offer(m, 20, ok);
    chk("full_stall_no_ack", 32'(ok), 32'd0);
    chk("full_stall_count", 32'(count), 32'd4);
    uart_en = 1'b1; uart_dly = 3;
    offer(m, 200, ok);
    chk("full_sixth_accepted", 32'(ok), 32'd1);
    wait_idle("full_drain", 400);

    // Accept on the same edge as an IDLE pop with two messages queued.
    uart_en = 1'b0;
    offer({5'd1, 5'd2, 4'd3}, 10, ok);
    chk("sim_accept_a", 32'(ok), 32'd1);
    offer({5'd4, 5'd5, 4'd6}, 10, ok);
    chk("sim_accept_b", 32'(ok), 32'd1);
    offer({5'd7, 5'd8, 4'd9}, 10, ok);
    chk("sim_accept_c", 32'(ok), 32'd1);
    chk("sim_count_before", 32'(count), 32'd2);
    target = done_cnt + 3;
    uart_en = 1'b1; uart_dly = 2;
    got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done_cnt == target) begin
        got = 1'b1;
        break;
      end
    end
    chk("sim_first_msg_done", 32'(got), 32'd1);
    @(negedge clk);
    chk("sim_idle_send_low", 32'(bus.send), 32'd0);
    chk("sim_idle_count", 32'(count), 32'd2);
    m = {5'd10, 5'd11, 4'd12};
    bus.txmessage       = m;
    bus.txmessage_valid = 1'b1;
    @(negedge clk);
    chk("sim_ack", 32'(bus.ack_txmessage), 32'd1);
    chk("sim_count_kept", 32'(count), 32'd2);
    chk("sim_pop_launch", 32'(bus.send), 32'd1);
    if (bus.ack_txmessage === 1'b1)
      push_msg(m);
    bus.txmessage_valid = 1'b0;
    wait_idle("sim_drain", 300);

    // Stray txdone in IDLE, then a random stream wrapping the pointers.
    uart_rand = 1'b1;
    stray_req = 1'b1;
    cycles(3);
    chk("stray_idle_fired", 32'(stray_req), 32'd0);
    chk("stray_idle_send", 32'(bus.send), 32'd0);
    chk("stray_idle_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 3 * DEPTH + 1; k++) begin
      if (k == 5)
        stray_req = 1'b1;
      offer(14'($urandom), 400, ok);
      chk("wrap_accept", 32'(ok), 32'd1);
    end
    wait_idle("wrap_drain", 1500);
    chk("stray_gap_fired", 32'(stray_req), 32'd0);
    uart_rand = 1'b0;

    // Reset in the middle of SEND discards everything queued.
    uart_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      offer({5'(k + 20), 5'(k + 4), 4'(k + 1)}, 10, ok);
      chk("rstmid_accept", 32'(ok), 32'd1);
    end
    cycles(2);
    chk("rstmid_pre_send", 32'(bus.send), 32'd1);
    chk("rstmid_pre_count", 32'(count), 32'd2);
    rst = 1'b1;
    #1;
    chk("rstmid_send", 32'(bus.send), 32'd0);
    chk("rstmid_txdata", 32'(bus.txdata), 32'h00);
    chk("rstmid_count", 32'(count), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_ack", 32'(bus.ack_txmessage), 32'd0);
    exp_q.delete();
    r0 = n_rises;
    cycles(2);
    rst = 1'b0;
    uart_en = 1'b1; uart_dly = 1;
    cycles(20);
    chk("rstmid_no_bytes_after", 32'(n_rises), 32'(r0));
    chk("rstmid_after_busy", 32'(busy), 32'd0);
    chk("rstmid_after_count", 32'(count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
